// File: rtl/lsq_mem_sched.sv
// Purpose: shares the single data-memory port between the load queue and the store data queue.
//          It arbitrates, holds the request until memory accepts it, tracks the one
//          outstanding load, and returns load data to its LDQ entry.
// Latency: grant and mem_req_valid appear 1 cycle after a request. ld_resp_valid appears 1 cycle after mem_resp_valid.
// Backpressure: a request is held stable while mem_req_ready is low. Requesters are ignored while busy.
// Ports:   ld_req_* / st_req_*  -> request inputs from the LDQ / SDQ. ld_grant / st_grant are the accept pulses.
//          mem_req_* / mem_resp_* -> memory port.
//          ld_resp_* -> load writeback. flush squashes in-flight loads. busy = not IDLE.
// Option:  define LSQ_SCHED_AGING_EN so that a waiting store wins after STARVE_LIMIT consecutive load grants.
module lsq_mem_sched #(
  parameter int LDQ_ENTRIES  = 16,
  parameter int SDQ_ENTRIES  = 16,
  parameter int STARVE_LIMIT = 8,
  localparam int LIW = $clog2(LDQ_ENTRIES),
  localparam int SIW = $clog2(SDQ_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_req_valid,
  input  logic [LIW-1:0]  ld_req_idx,
  input  logic [31:0]     ld_req_addr,
  output logic            ld_grant,
  input  logic            st_req_valid,
  input  logic [SIW-1:0]  st_req_idx,
  input  logic [31:0]     st_req_addr,
  input  logic [31:0]     st_req_data,
  output logic            st_grant,
  input  logic            flush,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [31:0]     mem_req_addr,
  output logic [31:0]     mem_req_wdata,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  output logic            ld_resp_valid,
  output logic [LIW-1:0]  ld_resp_idx,
  output logic [31:0]     ld_resp_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_q;
  logic             squash_q;
  logic [LIW-1:0]   idx_q;
  logic             age_force;
  logic             pick_st;
  logic             pick_ld;
  logic             arb_en;

  // A store never produces a response, so its SDQ index is not needed after the grant.
  logic unused_st_idx;
  assign unused_st_idx = ^st_req_idx;

`ifdef LSQ_SCHED_AGING_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] age_q;

  assign age_force = (age_q == CW'(STARVE_LIMIT));

  // Count the load grants issued while a store is waiting. The count saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (!st_req_valid) begin
      age_q <= '0;
    end else if (arb_en && pick_st) begin
      age_q <= '0;
    end else if (arb_en && pick_ld && !age_force) begin
      age_q <= age_q + CW'(1);
    end
  end
`else
  assign age_force = 1'b0;
`endif

  assign arb_en  = (state_q == IDLE) && !flush;
  assign pick_st = st_req_valid && (!ld_req_valid || age_force);
  assign pick_ld = ld_req_valid && !pick_st;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      squash_q      <= 1'b0;
      idx_q         <= '0;
      ld_grant      <= 1'b0;
      st_grant      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      ld_resp_valid <= 1'b0;
      ld_resp_idx   <= '0;
      ld_resp_data  <= '0;
    end else begin
      ld_grant      <= 1'b0;
      st_grant      <= 1'b0;
      ld_resp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_en && (pick_ld || pick_st)) begin
            state_q       <= REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= pick_st;
            mem_req_addr  <= pick_st ? st_req_addr : ld_req_addr;
            mem_req_wdata <= pick_st ? st_req_data : 32'd0;
            ld_grant      <= pick_ld;
            st_grant      <= pick_st;
            if (pick_ld) idx_q <= ld_req_idx;
          end
        end
        REQ: begin
          // A flushed load is not withdrawn. It is marked so that its data is discarded later.
          if (flush && !mem_req_we) squash_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= mem_req_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (flush) squash_q <= 1'b1;
          if (mem_resp_valid) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
            // A flush in the same cycle as the response also drops it.
            if (!squash_q && !flush) begin
              ld_resp_valid <= 1'b1;
              ld_resp_idx   <= idx_q;
              ld_resp_data  <= mem_resp_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_mem_sched.sv
// Purpose: directed self-checking bench for lsq_mem_sched.
// Latency: inputs are driven 1 time unit after the rising edge. Outputs are sampled on the falling edge.
// Backpressure: mem_req_ready and the memory response are driven directly by the stimulus.
module tb_lsq_mem_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req_valid = 1'b0;
  logic [3:0]  ld_req_idx = '0;
  logic [31:0] ld_req_addr = '0;
  logic        ld_grant;
  logic        st_req_valid = 1'b0;
  logic [3:0]  st_req_idx = '0;
  logic [31:0] st_req_addr = '0;
  logic [31:0] st_req_data = '0;
  logic        st_grant;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        ld_resp_valid;
  logic [3:0]  ld_resp_idx;
  logic [31:0] ld_resp_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsq_mem_sched dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_valid(ld_req_valid), .ld_req_idx(ld_req_idx), .ld_req_addr(ld_req_addr),
    .ld_grant(ld_grant),
    .st_req_valid(st_req_valid), .st_req_idx(st_req_idx), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_grant(st_grant),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ld_resp_valid(ld_resp_valid), .ld_resp_idx(ld_resp_idx), .ld_resp_data(ld_resp_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic g [18];
  int   ng;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_memv", 32'(mem_req_valid), 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_respv", 32'(ld_resp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    smp();

    // Lone store
    st_req_valid = 1'b1; st_req_idx = 4'd3; st_req_addr = 32'h100;
    st_req_data = 32'hDEADBEEF; mem_req_ready = 1'b1;
    tick(); st_req_valid = 1'b0;
    smp();
    chk("st_grant", 32'(st_grant), 32'd1);
    chk("st_memv", 32'(mem_req_valid), 32'd1);
    chk("st_we", 32'(mem_req_we), 32'd1);
    chk("st_addr", mem_req_addr, 32'h100);
    chk("st_wdata", mem_req_wdata, 32'hDEADBEEF);
    smp();
    chk("st_busy_t2", 32'(busy), 32'd0);
    chk("st_grant_t2", 32'(st_grant), 32'd0);
    chk("st_memv_t2", 32'(mem_req_valid), 32'd0);

    // Lone load with 3 cycles of backpressure. The response arrives 2 cycles after accept.
    mem_req_ready = 1'b0;
    ld_req_valid = 1'b1; ld_req_idx = 4'd5; ld_req_addr = 32'h40;
    tick(); ld_req_valid = 1'b0;
    smp();
    chk("ld_grant", 32'(ld_grant), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        tick();
        mem_req_ready = (i == 4);
        smp();
        chk("ld_grant_once", 32'(ld_grant), 32'd0);
      end
      chk("ld_hold_v", 32'(mem_req_valid), 32'd1);
      chk("ld_hold_addr", mem_req_addr, 32'h40);
      chk("ld_hold_we", 32'(mem_req_we), 32'd0);
      chk("ld_hold_wd", mem_req_wdata, 32'd0);
    end
    tick(); mem_req_ready = 1'b0;
    smp();
    chk("ld_wait_memv", 32'(mem_req_valid), 32'd0);
    chk("ld_wait_busy", 32'(busy), 32'd1);
    tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    smp();
    chk("ld_resp_early", 32'(ld_resp_valid), 32'd0);
    tick(); mem_resp_valid = 1'b0;
    smp();
    chk("ld_resp_v", 32'(ld_resp_valid), 32'd1);
    chk("ld_resp_idx", 32'(ld_resp_idx), 32'd5);
    chk("ld_resp_data", ld_resp_data, 32'h12345678);
    smp();
    chk("ld_resp_pulse", 32'(ld_resp_valid), 32'd0);

    // Contention: both queues request continuously. The memory answers in the first WAIT cycle.
    ld_req_valid = 1'b1; ld_req_idx = 4'd1; ld_req_addr = 32'h1000;
    st_req_valid = 1'b1; st_req_idx = 4'd2; st_req_addr = 32'h2000; st_req_data = 32'h55;
    mem_req_ready = 1'b1; mem_resp_data = 32'h77;
    ng = 0;
    for (int c = 0; c < 200 && ng < 18; c++) begin
      tick();
      mem_resp_valid = busy && !mem_req_valid;
      smp();
      if (ld_grant || st_grant) begin
        g[ng] = st_grant;
        ng++;
      end
    end
    chk("cont_ngrants", 32'(ng), 32'd18);
    for (int k = 0; k < ng; k++) begin
`ifdef LSQ_SCHED_AGING_EN
      chk($sformatf("cont_st_%0d", k), 32'(g[k]), 32'((k % 9) == 8));
`else
      chk($sformatf("cont_st_%0d", k), 32'(g[k]), 32'd0);
`endif
    end
    ld_req_valid = 1'b0; st_req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      mem_resp_valid = busy && !mem_req_valid;
    end
    mem_resp_valid = 1'b0;
    smp();
    chk("cont_drain", 32'(busy), 32'd0);

    // A flush in IDLE blocks arbitration. A flush in WAIT drops the response.
    ld_req_valid = 1'b1; ld_req_idx = 4'd2; ld_req_addr = 32'h80; flush = 1'b1;
    tick(); flush = 1'b0;
    smp();
    chk("idle_flush_blk", 32'(busy), 32'd0);
    tick(); ld_req_valid = 1'b0;
    smp();
    chk("fw_grant", 32'(ld_grant), 32'd1);
    tick(); flush = 1'b1;
    smp();
    chk("fw_in_wait", 32'(busy & ~mem_req_valid), 32'd1);
    tick(); flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA5555;
    tick(); mem_resp_valid = 1'b0;
    smp();
    chk("fw_dropped", 32'(ld_resp_valid), 32'd0);
    chk("fw_idle", 32'(busy), 32'd0);
    ld_req_valid = 1'b1; ld_req_idx = 4'd7; ld_req_addr = 32'h44;
    tick(); ld_req_valid = 1'b0;
    smp();
    chk("fw_next_grant", 32'(ld_grant), 32'd1);
    chk("fw_next_addr", mem_req_addr, 32'h44);
    tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h0BADF00D;
    tick(); mem_resp_valid = 1'b0;
    smp();
    chk("fw_next_v", 32'(ld_resp_valid), 32'd1);
    chk("fw_next_idx", 32'(ld_resp_idx), 32'd7);
    chk("fw_next_data", ld_resp_data, 32'h0BADF00D);

    // A flush in REQ under backpressure keeps the request asserted until it is accepted, then drops the response.
    mem_req_ready = 1'b0;
    ld_req_valid = 1'b1; ld_req_idx = 4'd9; ld_req_addr = 32'h200;
    tick(); ld_req_valid = 1'b0; flush = 1'b1;
    smp();
    chk("fr_memv", 32'(mem_req_valid), 32'd1);
    tick(); flush = 1'b0;
    smp();
    chk("fr_hold_v", 32'(mem_req_valid), 32'd1);
    chk("fr_hold_addr", mem_req_addr, 32'h200);
    tick(); mem_req_ready = 1'b1;
    tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h11112222;
    tick(); mem_resp_valid = 1'b0;
    smp();
    chk("fr_dropped", 32'(ld_resp_valid), 32'd0);
    chk("fr_idle", 32'(busy), 32'd0);

    // A flush in the same cycle as the response also drops the response.
    ld_req_valid = 1'b1; ld_req_idx = 4'd1; ld_req_addr = 32'h300; mem_req_ready = 1'b1;
    tick(); ld_req_valid = 1'b0;
    tick(); flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h33334444;
    tick(); flush = 1'b0; mem_resp_valid = 1'b0;
    smp();
    chk("fs_dropped", 32'(ld_resp_valid), 32'd0);

    // A store in REQ is unaffected by a flush, and the following load still returns its data.
    st_req_valid = 1'b1; st_req_idx = 4'd4; st_req_addr = 32'h500;
    st_req_data = 32'hCAFEF00D; mem_req_ready = 1'b0;
    tick(); st_req_valid = 1'b0; flush = 1'b1;
    smp();
    chk("sf_grant", 32'(st_grant), 32'd1);
    tick(); flush = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("sf_memv", 32'(mem_req_valid), 32'd1);
    chk("sf_wdata", mem_req_wdata, 32'hCAFEF00D);
    tick(); mem_req_ready = 1'b0;
    smp();
    chk("sf_done", 32'(busy), 32'd0);
    ld_req_valid = 1'b1; ld_req_idx = 4'd3; ld_req_addr = 32'h600; mem_req_ready = 1'b1;
    tick(); ld_req_valid = 1'b0;
    tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h600D600D;
    tick(); mem_resp_valid = 1'b0;
    smp();
    chk("sf_ld_v", 32'(ld_resp_valid), 32'd1);
    chk("sf_ld_data", ld_resp_data, 32'h600D600D);

    // Asynchronous reset while a load is in WAIT
    ld_req_valid = 1'b1; ld_req_idx = 4'd6; ld_req_addr = 32'h700; mem_req_ready = 1'b1;
    tick(); ld_req_valid = 1'b0;
    tick(); mem_req_ready = 1'b0;
    smp();
    chk("ar_in_wait", 32'(busy & ~mem_req_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_memv", 32'(mem_req_valid), 32'd0);
    chk("ar_addr", mem_req_addr, 32'd0);
    chk("ar_grant", 32'({ld_grant, st_grant}), 32'd0);
    tick(); rst_n = 1'b1;
    tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'h99999999;
    tick(); mem_resp_valid = 1'b0;
    smp();
    chk("ar_stray", 32'(ld_resp_valid), 32'd0);
    chk("ar_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsq_mem_sched.md
# lsq_mem_sched

Scheduler for the single data-memory port shared by the load queue (LDQ) and the store data queue (SDQ). Each cycle the block selects one requester: a ready load from the LDQ, or a committed store draining from the SDQ. It then drives the memory request handshake, tracks the one outstanding load, and routes the load response back to its LDQ entry. Loads are squashed on pipeline flush; committed stores are never squashed.

## Interface
Parameters:
- LDQ_ENTRIES, 16, load queue depth; LIW = $clog2(LDQ_ENTRIES)
- SDQ_ENTRIES, 16, store queue depth; SIW = $clog2(SDQ_ENTRIES)
- STARVE_LIMIT, 8, consecutive load grants tolerated while a store waits (aging only)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_req_valid  in  1  LDQ has an address-valid, unissued load
- ld_req_idx  in  LIW  LDQ entry index
- ld_req_addr  in  32  load address
- ld_grant  out  1  one-cycle pulse: load accepted; LDQ marks entry issued
- st_req_valid  in  1  SDQ head is committed, address-valid, unissued
- st_req_idx  in  SIW  SDQ entry index
- st_req_addr  in  32  store address
- st_req_data  in  32  store data
- st_grant  out  1  one-cycle pulse: store accepted; SDQ marks entry issued
- flush  in  1  squash all in-flight loads
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = store, 0 = load
- mem_req_addr  out  32  request address
- mem_req_wdata  out  32  store data (0 for loads)
- mem_resp_valid  in  1  load data returned
- mem_resp_data  in  32  load data
- ld_resp_valid  out  1  one-cycle pulse: load data to LDQ/writeback
- ld_resp_idx  out  LIW  LDQ index of the response
- ld_resp_data  out  32  load data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Arbitrate unless flush is high.
  - Default policy: load wins; store wins only when no load is requesting.
  - On a win, capture idx/addr/data/we into holding registers and go to REQ.
- REQ:
  - mem_req_valid = 1 with stable holding values until mem_req_ready.
  - On accept: store goes to IDLE; load goes to WAIT.
- WAIT:
  - On mem_resp_valid, go to IDLE.
  - If not squashed, pulse ld_resp_valid next cycle with the held idx and the response data.
- Request inputs are ignored outside IDLE.
- mem_resp_valid is ignored outside WAIT.
- flush:
  - In IDLE: blocks arbitration that cycle.
  - During a load in REQ: mem_req_valid stays asserted until accepted (no withdraw), and a squash flag is set.
  - During a load in WAIT: the squash flag is set.
  - A squashed load still waits for its response, then drops it (no ld_resp_valid).
  - Stores are unaffected.
  - The squash flag clears on return to IDLE.
- Simultaneous flush and mem_resp_valid in WAIT: the response is dropped.

## Timing
- Reset: state IDLE; all outputs 0; holding registers, squash flag and aging counter 0.
- ld_grant / st_grant are registered and high during the first REQ cycle only.
- Best-case store: request seen at cycle t, grant and mem_req_valid at t+1, accepted at t+1, next arbitration at t+2.
- Best-case load: request at t, mem_req accepted at t+1, response at t+2, ld_resp_valid at t+3.
- Reset asserted mid-transaction: immediate return to IDLE; the outstanding request and response are abandoned.

## Configuration
- LSQ_SCHED_AGING_EN defined:
  - Saturating counter of width $clog2(STARVE_LIMIT+1) counts load grants issued while st_req_valid is high.
  - It clears on st_grant or whenever st_req_valid is low.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration with st_req_valid high grants the store, even if a load is requesting.
- Not defined: no counter; strict load priority. A store can starve indefinitely under continuous load traffic.

## Test plan
- Lone store: st_req_valid=1, idx=3, addr=0x100, data=0xDEADBEEF, mem_req_ready=1 -> st_grant pulse at t+1; mem_req we=1, addr=0x100, wdata=0xDEADBEEF for 1 cycle; busy low at t+2.
- Lone load with backpressure: ld idx=5, addr=0x40; mem_req_ready low for 3 cycles; response 0x12345678 two cycles after accept -> request held stable for 4 cycles; ld_resp_valid with idx=5, data=0x12345678 one cycle after mem_resp_valid.
- Contention: ld_req_valid and st_req_valid both continuously high, ready=1, response latency 1:
  - Without aging: only loads are granted.
  - With LSQ_SCHED_AGING_EN and STARVE_LIMIT=8: 8 ld_grants, then 1 st_grant, repeating.
- Flush in WAIT: load idx=2 outstanding; flush pulses; response arrives -> no ld_resp_valid; next request granted normally.
- Flush in REQ with mem_req_ready low: mem_req_valid stays high until accept; the later response is dropped. A store in REQ under flush completes normally.
- Async reset asserted in WAIT -> all outputs 0 immediately; a later stray mem_resp_valid produces no ld_resp_valid.
